// File: rtl/rf_writeback.sv
// Register-file write-side master: LSU-over-ALU write-port arbitration plus a
// per-register pending-write scoreboard for decode-stage RAW hazard queries.
module rf_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_NUM_BIT-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [REG_NUM_BIT-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [REG_NUM_BIT-1:0] iss_rd,
    input  logic [REG_NUM_BIT-1:0] q_a,
    input  logic [REG_NUM_BIT-1:0] q_b,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic                   rf_wen,
    output logic [REG_NUM_BIT-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata
);

    logic [1:0]             cnt [REG_NUM];
    logic [REG_NUM-1:0]     inc_vec;
    logic [REG_NUM-1:0]     dec_vec;
    logic                   acc_valid;
    logic [REG_NUM_BIT-1:0] acc_rd;
    logic [DATA_WIDTH-1:0]  acc_data;
    logic                   inc_en;

    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;

    always_comb begin
        acc_valid = lsu_valid || alu_valid;
        acc_rd    = lsu_valid ? lsu_rd   : alu_rd;
        acc_data  = lsu_valid ? lsu_data : alu_data;
    end

    // Readies and busy flags look only at valids, indices and counters.
    always_comb begin
        iss_ready = 1'b1;
        if (iss_rd != '0 && int'(iss_rd) < REG_NUM)
            iss_ready = (cnt[iss_rd] != 2'd3);
        busy_a = 1'b0;
        if (q_a != '0 && int'(q_a) < REG_NUM)
            busy_a = (cnt[q_a] != 2'd0);
        busy_b = 1'b0;
        if (q_b != '0 && int'(q_b) < REG_NUM)
            busy_b = (cnt[q_b] != 2'd0);
    end

    assign inc_en = iss_valid && iss_ready && (iss_rd != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            inc_vec[r] = inc_en && (iss_rd == REG_NUM_BIT'(r));
            dec_vec[r] = rf_wen && (rf_waddr == REG_NUM_BIT'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            for (int unsigned r = 0; r < REG_NUM; r++)
                cnt[r] <= '0;
        end else begin
            // rd = 0 completes the handshake but never reaches the write port.
            rf_wen <= acc_valid && (acc_rd != '0);
            if (acc_valid && acc_rd != '0) begin
                rf_waddr <= acc_rd;
                rf_wdata <= acc_data;
            end
            cnt[0] <= '0;
            for (int unsigned r = 1; r < REG_NUM; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + 2'd1;
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != 2'd0)
                    cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed vector table for the named corner cases,
// then randomized traffic against a behavioural scoreboard model.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, iss_valid;
    logic        alu_ready, lsu_ready, iss_ready;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, q_a, q_b;
    logic [31:0] alu_data, lsu_data;
    logic        busy_a, busy_b, rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rf_writeback #(.DATA_WIDTH(32), .REG_NUM(32), .REG_NUM_BIT(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .q_a(q_a), .q_b(q_b), .busy_a(busy_a), .busy_b(busy_b),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        rst, av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ird, qa, qb;
        logic        ar, ir, ba, bb, wen, chkd;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic r, input logic av, input int ard, input logic [31:0] ad,
        input logic lv, input int lrd, input logic [31:0] ld,
        input logic iv, input int ird, input int qa, input int qb,
        input logic ar, input logic ir, input logic ba, input logic bb,
        input logic wen, input logic chkd, input int waddr, input logic [31:0] wdata);
        vec_t t;
        t.rst = r;  t.av = av; t.ard = 5'(ard); t.ad = ad;
        t.lv = lv;  t.lrd = 5'(lrd); t.ld = ld;
        t.iv = iv;  t.ird = 5'(ird); t.qa = 5'(qa); t.qb = 5'(qb);
        t.ar = ar;  t.ir = ir; t.ba = ba; t.bb = bb;
        t.wen = wen; t.chkd = chkd; t.waddr = 5'(waddr); t.wdata = wdata;
        return t;
    endfunction

    // Behavioural model: pending-write counts plus the registered write port.
    int          m_cnt [32];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic logic m_busy(input logic [4:0] q);
        return (q != 0) && (m_cnt[q] > 0);
    endfunction

    function automatic logic m_iss_ready();
        return (iss_rd == 0) || (m_cnt[iss_rd] < 3);
    endfunction

    task automatic model_update();
        logic        take;
        logic [4:0]  rd;
        logic [31:0] d;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_wen = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            take = lsu_valid || alu_valid;
            rd   = lsu_valid ? lsu_rd : alu_rd;
            d    = lsu_valid ? lsu_data : alu_data;
            if (iss_valid && m_iss_ready() && iss_rd != 0)
                m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
            if (m_wen && m_cnt[m_waddr] > 0)
                m_cnt[m_waddr] = m_cnt[m_waddr] - 1;
            m_wen = take && (rd != 0);
            if (m_wen) begin
                m_waddr = rd;
                m_wdata = d;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        logic pend;
        rst = 1; alu_valid = 0; lsu_valid = 0; iss_valid = 0;
        alu_rd = 0; lsu_rd = 0; iss_rd = 0; q_a = 0; q_b = 0;
        alu_data = 0; lsu_data = 0;
        clock_edge();

        // r  av ard ad            lv lrd ld     iv ird qa qb  ar ir ba bb  wen chkd waddr wdata
        tbl.push_back(v(1, 1, 1, 32'h5,        0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 32'h5,        0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 5, 5, 0,  1, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(v(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 5, 0,  1, 1, 1, 0,  1, 1, 5, 32'hDEADBEEF));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 5, 0,  1, 1, 1, 0,  0, 1, 5, 32'hDEADBEEF));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 5, 0,  1, 1, 0, 0,  0, 1, 5, 32'hDEADBEEF));
        tbl.push_back(v(0, 1, 3, 32'h1,        1, 4, 32'h2,  0, 0, 0, 0,  0, 1, 0, 0,  1, 1, 4, 32'h2));
        tbl.push_back(v(0, 1, 3, 32'h1,        0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 3, 32'h1));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  0, 1, 3, 32'h1));
        tbl.push_back(v(0, 1, 0, 32'h1234,     0, 0, 0,      1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 7, 7, 0,  1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 7, 7, 0,  1, 1, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 7, 7, 0,  1, 1, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 7, 7, 0,  1, 0, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 8, 7, 8,  1, 1, 1, 0,  0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 32'h77,       0, 0, 0,      0, 7, 7, 0,  1, 0, 1, 0,  1, 1, 7, 32'h77));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 7, 7, 0,  1, 0, 1, 0,  0, 1, 7, 32'h77));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 7, 7, 0,  1, 1, 1, 0,  0, 1, 7, 32'h77));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 9, 9, 0,  1, 1, 0, 0,  0, 1, 7, 32'h77));
        tbl.push_back(v(0, 1, 9, 32'h99,       0, 0, 0,      0, 0, 9, 0,  1, 1, 1, 0,  1, 1, 9, 32'h99));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      1, 9, 9, 0,  1, 1, 1, 0,  0, 1, 9, 32'h99));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 9, 7,  1, 1, 1, 1,  0, 1, 9, 32'h99));
        tbl.push_back(v(1, 0, 0, 0,            1, 10, 32'hAA, 0, 0, 9, 7,  0, 1, 1, 1,  0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,      0, 0, 9, 7,  1, 1, 0, 0,  0, 1, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; q_a = tbl[i].qa; q_b = tbl[i].qb;
            #2;
            chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
            chk($sformatf("vec%0d lsu_ready", i), 32'(lsu_ready), 32'd1);
            chk($sformatf("vec%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d busy_a", i),    32'(busy_a),    32'(tbl[i].ba));
            chk($sformatf("vec%0d busy_b", i),    32'(busy_b),    32'(tbl[i].bb));
            clock_edge();
            chk($sformatf("vec%0d rf_wen", i), 32'(rf_wen), 32'(tbl[i].wen));
            if (tbl[i].chkd) begin
                chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].wdata);
            end
        end

        // Random traffic; a stalled ALU result is held stable until accepted.
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!pend) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            lsu_valid = ($urandom_range(0, 3) == 0);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 7));
            q_a       = 5'($urandom_range(0, 7));
            q_b       = 5'($urandom_range(0, 7));
            #2;
            chk("rnd alu_ready", 32'(alu_ready), 32'(!lsu_valid));
            chk("rnd lsu_ready", 32'(lsu_ready), 32'd1);
            chk("rnd iss_ready", 32'(iss_ready), 32'(m_iss_ready()));
            chk("rnd busy_a",    32'(busy_a),    32'(m_busy(q_a)));
            chk("rnd busy_b",    32'(busy_b),    32'(m_busy(q_b)));
            pend = alu_valid && lsu_valid;
            clock_edge();
            chk("rnd rf_wen", 32'(rf_wen), 32'(m_wen));
            if (m_wen) begin
                chk("rnd rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                chk("rnd rf_wdata", rf_wdata, m_wdata);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
